// File: rtl/handshake_tx_ctrl_if.sv
// Stream and CDC-launch signals of the handshake write-domain front end.
// The slave side is the controller; the master side is the stream source
// together with the downstream handshake block.
interface handshake_tx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] xfer_data;
  logic                  start;
  logic                  done;

  modport master (
    output in_data,
    output in_valid,
    output done,
    input  in_ready,
    input  xfer_data,
    input  start
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  done,
    output in_ready,
    output xfer_data,
    output start
  );
endinterface

// File: rtl/handshake_tx_ctrl.sv
// Write-domain front end for the handshake CDC: buffers stream words in a
// small FIFO and launches them one at a time on a stable holding register,
// waiting for done before launching the next word.
module handshake_tx_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH          = 4,    // power of 2, >= 2
  parameter int unsigned TIMEOUT_CYCLES = 1024  // 0 disables the timeout
) (
  input  logic                 clk,
  input  logic                 rst_n,
  handshake_tx_ctrl_if.slave   bus,
  input  logic                 err_clr,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [15:0]          words_sent
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);
  localparam logic [TW-1:0] TMax = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TOne = TW'(1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wptr_q, rptr_q;  // top bit is the wrap bit
  logic [DATA_WIDTH-1:0] xfer_q;
  logic                  start_q;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  err_q, err_d, err_set;
  logic [15:0]           words_sent_q;

  logic full, empty, push, pop, done_ok;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push  = bus.in_valid && !full;

  assign bus.in_ready  = !full;
  assign bus.xfer_data = xfer_q;
  assign bus.start     = start_q;
  assign busy          = (state_q != StIdle);
  assign timeout_err   = err_q;
  assign words_sent    = words_sent_q;

  // Next-state decode; pop is only ever requested by the FSM.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done_ok = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StLaunch;
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        if (bus.done) begin
          done_ok = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            state_d = StLaunch;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Timeout counter: cleared on WAIT entry, saturates at TIMEOUT_CYCLES.
  always_comb begin
    tcnt_d  = tcnt_q;
    err_set = 1'b0;
    if (state_q == StLaunch) begin
      tcnt_d = '0;
    end else if (state_q == StWait && !bus.done && TIMEOUT_CYCLES != 0) begin
      if (tcnt_q != TMax) begin
        tcnt_d = tcnt_q + TOne;
        if (tcnt_q == TMax - TOne) err_set = 1'b1;
      end
    end
    // A set in the same cycle as a clear wins.
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  // FSM, pointers, holding register and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      rptr_q       <= '0;
      xfer_q       <= '0;
      start_q      <= 1'b0;
      tcnt_q       <= '0;
      err_q        <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= (state_d == StLaunch);
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop) begin
        rptr_q <= rptr_q + PtrOne;
        xfer_q <= mem_q[rptr_q[AW-1:0]];
      end
      if (done_ok) words_sent_q <= words_sent_q + 16'd1;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q[AW-1:0]] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_handshake_tx_ctrl.sv
// Self-checking bench for handshake_tx_ctrl: directed scenarios plus a random
// phase, every cycle compared against a queue-based transaction model.
module tb_handshake_tx_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int T     = 16;

  logic        clk;
  logic        rst_n;
  logic        err_clr;
  logic        busy;
  logic        timeout_err;
  logic [15:0] words_sent;

  handshake_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  handshake_tx_ctrl #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .err_clr    (err_clr),
    .busy       (busy),
    .timeout_err(timeout_err),
    .words_sent (words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Transaction model: FIFO as a queue, one word in flight at a time.
  logic [DW-1:0] m_fifo[$];
  bit            m_launch;  // start is high this cycle
  bit            m_wait;    // waiting for done
  int            m_wcnt;
  bit            m_err;
  logic [DW-1:0] m_xfer;
  logic [15:0]   m_words;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_launch = 0;
    m_wait   = 0;
    m_wcnt   = 0;
    m_err    = 0;
    m_xfer   = '0;
    m_words  = '0;
  endtask

  task automatic model_edge();
    bit ready, push, fin, pop, eset;
    ready = m_fifo.size() < DEPTH;
    push  = bus.in_valid && ready;
    fin   = m_wait && bus.done;
    pop   = (m_fifo.size() > 0) && (fin || (!m_launch && !m_wait));
    if (pop) m_xfer = m_fifo.pop_front();
    if (push) m_fifo.push_back(bus.in_data);
    if (fin) m_words++;
    eset = 0;
    if (m_wait && !bus.done && m_wcnt < T) begin
      m_wcnt++;
      if (m_wcnt == T) eset = 1;
    end
    if (m_launch) m_wcnt = 0;
    if (eset) m_err = 1;
    else if (err_clr) m_err = 0;
    m_wait   = m_launch || (m_wait && !bus.done);
    m_launch = pop;
  endtask

  task automatic check_all();
    check("in_ready", 64'(bus.in_ready), 64'(m_fifo.size() < DEPTH));
    check("start", 64'(bus.start), 64'(m_launch));
    check("busy", 64'(busy), 64'(m_launch || m_wait));
    check("xfer_data", 64'(bus.xfer_data), 64'(m_xfer));
    check("timeout_err", 64'(timeout_err), 64'(m_err));
    check("words_sent", 64'(words_sent), 64'(m_words));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later,
  // returns at the falling edge ready for new stimulus.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid = 0;
    while ((busy || m_fifo.size() > 0) && n < 200) begin
      bus.done = busy && !bus.start;
      step();
      n++;
    end
    bus.done = 0;
    check("drain_done", 64'(busy), 64'(0));
  endtask

  initial begin
    int idx, n;
    logic [15:0] base;
    rst_n        = 0;
    err_clr      = 0;
    bus.in_valid = 0;
    bus.in_data  = '0;
    bus.done     = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_start", 64'(bus.start), 64'(0));
    check("rst_xfer", 64'(bus.xfer_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(timeout_err), 64'(0));
    check("rst_words", 64'(words_sent), 64'(0));
    rst_n = 1;

    // Single word: start one cycle after acceptance, done six cycles later.
    bus.in_valid = 1;
    bus.in_data  = 32'hA5A5_0001;
    step();
    bus.in_valid = 0;
    step();
    check("t1_start", 64'(bus.start), 64'(1));
    check("t1_xfer", 64'(bus.xfer_data), 64'hA5A5_0001);
    step();
    repeat (5) step();
    bus.done = 1;
    step();
    bus.done = 0;
    step();
    check("t1_words", 64'(words_sent), 64'(1));
    check("t1_busy", 64'(busy), 64'(0));

    // Six words with done withheld: FIFO fills, then drains in order.
    base = m_words;
    idx  = 0;
    repeat (10) begin
      bus.in_valid = (idx < 6);
      bus.in_data  = 32'hB000_0000 + 32'(idx);
      if (bus.in_valid && bus.in_ready) begin
        step();
        idx++;
      end else begin
        step();
      end
    end
    check("t2_full", 64'(bus.in_ready), 64'(0));
    n = 0;
    while ((idx < 6 || busy || m_fifo.size() > 0) && n < 100) begin
      bus.in_valid = (idx < 6);
      bus.in_data  = 32'hB000_0000 + 32'(idx);
      bus.done     = busy && !bus.start;
      if (bus.in_valid && bus.in_ready) idx++;
      step();
      n++;
    end
    bus.in_valid = 0;
    bus.done     = 0;
    check("t2_words", 64'(words_sent), 64'(base + 16'd6));

    // done in IDLE and during LAUNCH is ignored.
    base     = m_words;
    bus.done = 1;
    step();
    check("t3_idle_words", 64'(words_sent), 64'(base));
    bus.done     = 0;
    bus.in_valid = 1;
    bus.in_data  = 32'hC0DE_0003;
    step();
    bus.in_valid = 0;
    bus.done     = 1;
    step();
    check("t3_launch", 64'(bus.start), 64'(1));
    step();
    check("t3_launch_words", 64'(words_sent), 64'(base));
    check("t3_no_restart", 64'(bus.start), 64'(0));
    step();
    bus.done = 0;
    check("t3_words", 64'(words_sent), 64'(base + 16'd1));

    // Timeout after exactly T WAIT cycles; late done completes; err_clr clears.
    err_clr = 1;
    step();
    err_clr      = 0;
    bus.in_valid = 1;
    bus.in_data  = 32'hD00D_0004;
    step();
    bus.in_valid = 0;
    step();
    step();
    repeat (T - 1) step();
    check("t4_err_early", 64'(timeout_err), 64'(0));
    step();
    check("t4_err_set", 64'(timeout_err), 64'(1));
    check("t4_busy", 64'(busy), 64'(1));
    repeat (3) step();
    base     = m_words;
    bus.done = 1;
    step();
    bus.done = 0;
    check("t4_late_done", 64'(words_sent), 64'(base + 16'd1));
    check("t4_err_sticky", 64'(timeout_err), 64'(1));
    err_clr = 1;
    step();
    err_clr = 0;
    check("t4_err_clr", 64'(timeout_err), 64'(0));

    // Random traffic, including stray done pulses and clears.
    repeat (400) begin
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_data  = $urandom;
      bus.done     = ($urandom_range(0, 3) == 0);
      err_clr      = ($urandom_range(0, 15) == 0);
      step();
    end
    err_clr = 0;
    drain();

    // Counter wrap from 0xFFFF.
    bus.in_valid = 1;
    bus.in_data  = 32'hE000_0005;
    step();
    bus.in_valid = 0;
    step();
    step();
    force dut.words_sent_q = 16'hFFFF;
    m_words = 16'hFFFF;
    #1 release dut.words_sent_q;
    bus.done = 1;
    step();
    bus.done = 0;
    check("t5_wrap", 64'(words_sent), 64'(0));

    // Asynchronous reset mid-WAIT with three words queued.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1;
      bus.in_data  = 32'hF000_0000 + 32'(i);
      step();
    end
    bus.in_valid = 0;
    check("t6_in_wait", 64'(busy && !bus.start), 64'(1));
    #2 rst_n = 0;
    #1;
    model_reset();
    check("t6_rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("t6_rst_start", 64'(bus.start), 64'(0));
    check("t6_rst_xfer", 64'(bus.xfer_data), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_words", 64'(words_sent), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (5) step();
    check("t6_no_start", 64'(bus.start), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/handshake_tx_ctrl.md
# handshake_tx_ctrl

Write-domain front end for the `handshake` clock-domain crossing. It accepts words from a valid/ready stream and buffers them in a small FIFO. It presents one word at a time on a stable holding register, pulses `start`, then waits for `done` before launching the next word. Placement: directly upstream of `handshake`, in the `clk_wr` domain; `xfer_data` is the quasi-static bus that the read domain samples when `read_it` pulses.

## Interface
- `DATA_WIDTH`, default 32: width of stream and holding register.
- `DEPTH`, default 4: FIFO entries; a power of 2, ≥2.
- `TIMEOUT_CYCLES`, default 1024: WAIT cycles before `timeout_err` sets; 0 disables the timeout.
- `clk` in 1: write-domain clock; one clock only.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in DATA_WIDTH: stream data.
- `in_valid` in 1: stream valid.
- `in_ready` out 1: stream ready; equals FIFO not full.
- `xfer_data` out DATA_WIDTH: holding register, wired to the CDC data bus.
- `start` out 1: one-cycle launch pulse, to `handshake.start`.
- `done` in 1: one-cycle completion pulse, from `handshake.done`.
- `busy` out 1: high while a word is in flight (state LAUNCH or WAIT).
- `timeout_err` out 1: sticky flag; `done` has not arrived within TIMEOUT_CYCLES.
- `err_clr` in 1: clears `timeout_err`.
- `words_sent` out 16: count of completed transfers; wraps.

## Operation
- **Reset values.** All state clears: FIFO empty, `in_ready`=1, `start`=0, `xfer_data`=0, `busy`=0, `timeout_err`=0, `words_sent`=0, state=IDLE.
- **Push.** A push occurs on `in_valid && in_ready`.
  - Pop is driven only by the FSM.
  - A push and a pop in the same cycle leave the occupancy unchanged.
  - When the FIFO is full, `in_ready`=0 and input is ignored.
- **Occupancy.** Tracked with a log2(DEPTH)+1-bit count, or with pointers carrying a wrap bit.
  - Read and write pointers wrap modulo DEPTH.
- **FSM states:** IDLE, LAUNCH, WAIT.
  - **IDLE:** if the FIFO is non-empty, pop the head into `xfer_data` and go to LAUNCH.
  - **LAUNCH:** `start`=1 for exactly this cycle; go to WAIT.
  - **WAIT:** on `done`, increment `words_sent`.
    - If the FIFO is non-empty, pop the next word into `xfer_data` and go to LAUNCH (back-to-back).
    - Otherwise go to IDLE.
- **Data stability.** `xfer_data` changes only on a pop. It is stable from LAUNCH until the cycle after `done`.
- **`done` outside WAIT** is ignored: no state change, no count.
- **Timeout.**
  - The counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES, `timeout_err` sets and the counter saturates.
  - The FSM keeps waiting; an in-flight toggle handshake cannot be aborted safely.
  - `err_clr` clears the flag. If `err_clr` and a set occur in the same cycle, set wins.
- **`words_sent`** wraps from 0xFFFF to 0x0000.
- **Reset mid-operation.** Returns to the reset values immediately. The system must reset `handshake` in the same event, or the toggle parity desynchronises.

## Timing
- All outputs are registered except `in_ready` and `busy`, which are decoded from registered state.
- **Input-to-start latency** from an empty, IDLE state: push accepted at edge N; pop and LAUNCH at edge N+1; `start` high during cycle N+1→N+2. Latency = 1 cycle after acceptance.
- **Back-to-back:** `done` high in cycle M gives `start` high in cycle M+1. The launch interval is therefore the handshake round trip + 1.
- **FIFO full:** `in_ready` drops the cycle after the push that fills it.
  - A pop in a full cycle raises `in_ready` the next cycle.
- **Timeout:** `timeout_err` rises TIMEOUT_CYCLES cycles after WAIT entry when no `done` arrives.

## Test plan
- Reset, then one word 0xA5A5_0001 → `start` 1 cycle after acceptance, `xfer_data`=0xA5A5_0001; `done` 6 cycles later → IDLE, `words_sent`=1, `busy`=0.
- Push 6 words with DEPTH=4 and `done` withheld → FIFO holds 4, `in_ready`=0; release `done` pulses → all 6 words appear in order, one `start` per `done`, `words_sent`=6.
- `done` pulsed in IDLE and again during LAUNCH → ignored; `words_sent` unchanged, no extra `start`.
- TIMEOUT_CYCLES=16, `done` withheld → `timeout_err`=1 after 16 WAIT cycles, `busy` stays 1; late `done` → completes normally; `err_clr` → flag 0.
- Preload `words_sent`=0xFFFF via 65535 transfers, or force the register → next `done` gives 0x0000.
- Assert `rst_n` low mid-WAIT with 3 words queued → all outputs at reset values asynchronously; after release, no `start` until a new push.
